// File: rtl/mc_pkg.sv
// mc_pkg: shared types, ALU opcodes, control bundle and instruction field
// positions for the multicycle datapath.
package mc_pkg;

    typedef enum logic [2:0] {DP_REG, DP_IMM, LDR, STR, BR} op_t;

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC, ALUWB, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_ORR = 3'd3;
    localparam logic [2:0] ALU_EOR = 3'd4;
    localparam logic [2:0] ALU_MOV = 3'd5;
    localparam logic [2:0] ALU_BIC = 3'd6;
    localparam logic [2:0] ALU_MVN = 3'd7;

    localparam int RN_LSB    = 16;
    localparam int RD_LSB    = 12;
    localparam int RM_LSB    = 0;
    localparam int SH_LSB    = 5;
    localparam int SHAMT_LSB = 7;
    localparam int U_BIT     = 23;

    typedef struct packed {
        logic ir_we;
        logic rd_we;
        logic ex_we;
        logic adr_we;
        logic data_we;
        logic rf_alu;
        logic rf_data;
        logic br_we;
        logic mem_req;
        logic mem_we;
        logic addr_alu;
        logic retire;
    } ctrl_t;

endpackage

// File: rtl/mc_fsm.sv
// mc_fsm: sequencing state machine; turns state, op class and memory
// handshake into per-cycle register enables and memory control.
module mc_fsm
    import mc_pkg::*;
(
    input  logic   clk,
    input  logic   reset_n,
    input  op_t    op_class,
    input  logic   cond_ex,
    input  logic   mem_ready,
    output state_t state,
    output ctrl_t  ctrl
);

    state_t next;

    always_ff @(posedge clk)
        state <= !reset_n ? FETCH : next;

    always_comb begin
        next = state;
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_req = 1'b1;
                ctrl.ir_we   = mem_ready;
                next         = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ctrl.rd_we  = cond_ex;
                next        = !cond_ex ? FETCH
                            : (op_class == DP_REG || op_class == DP_IMM) ? EXEC
                            : (op_class == LDR || op_class == STR) ? MEMADR
                            : op_class == BR ? BRANCH : FETCH;
                ctrl.retire = next == FETCH;
            end
            EXEC: begin
                ctrl.ex_we = 1'b1;
                next       = ALUWB;
            end
            ALUWB: begin
                ctrl.rf_alu = 1'b1;
                ctrl.retire = 1'b1;
                next        = FETCH;
            end
            MEMADR: begin
                ctrl.adr_we = 1'b1;
                next        = op_class == STR ? MEMWR : MEMRD;
            end
            MEMRD: begin
                ctrl.mem_req  = 1'b1;
                ctrl.addr_alu = 1'b1;
                ctrl.data_we  = mem_ready;
                next          = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                ctrl.rf_data = 1'b1;
                ctrl.retire  = 1'b1;
                next         = FETCH;
            end
            MEMWR: begin
                ctrl.mem_req  = 1'b1;
                ctrl.mem_we   = 1'b1;
                ctrl.addr_alu = 1'b1;
                ctrl.retire   = mem_ready;
                next          = mem_ready ? FETCH : MEMWR;
            end
            BRANCH: begin
                ctrl.br_we  = 1'b1;
                ctrl.retire = 1'b1;
                next        = FETCH;
            end
            default: next = FETCH;
        endcase
        // reset suppresses every side effect, including register-file writes
        if (!reset_n) ctrl = '0;
    end

endmodule

// File: rtl/mc_datapath.sv
// mc_datapath: multicycle ARM-style datapath with a shared memory port,
// non-architectural step registers and an embedded sequencer.
module mc_datapath
    import mc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 16,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  op_t             op_class,
    input  logic [2:0]      alu_ctrl,
    input  logic [1:0]      imm_src,
    input  logic            flag_we,
    input  logic            cond_ex,
    output logic [XLEN-1:0] instr,
    output logic [3:0]      alu_flags,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic            retire,
    output logic [3:0]      state
);

    localparam logic [3:0] PCI = 4'(NREGS - 1);

    state_t st;
    ctrl_t  c;

    logic [XLEN-1:0] rf [NREGS-1];
    logic [XLEN-1:0] pc, a_q, wd_q, alu_q, data_q;
    logic [23:0]     iw;
    logic [3:0]      rn, rd, rm, ra, rb;
    logic [4:0]      shamt, rot;
    logic [1:0]      sh;
    logic [XLEN-1:0] a_rd, b_rd, ext, shifted, srcb, srcb_n, res, adr, wb_val;
    logic signed [XLEN-1:0] asr;
    logic [XLEN:0]   sum;
    logic            sub_op, arith, ovf;
    logic [3:0]      nzcv;

    mc_fsm u_fsm (
        .clk      (clk),
        .reset_n  (reset_n),
        .op_class (op_class),
        .cond_ex  (cond_ex),
        .mem_ready(mem_ready),
        .state    (st),
        .ctrl     (c)
    );

    assign iw    = 24'(instr);
    assign rn    = iw[RN_LSB +: 4];
    assign rd    = iw[RD_LSB +: 4];
    assign rm    = iw[RM_LSB +: 4];
    assign sh    = iw[SH_LSB +: 2];
    assign shamt = iw[SHAMT_LSB +: 5];

    // branches take their base from the PC alias, not from the Rn field
    assign ra   = op_class == BR ? PCI : rn;
    assign rb   = op_class == DP_REG ? rm : rd;
    assign a_rd = ra == PCI ? pc + XLEN'(4) : rf[ra];
    assign b_rd = rb == PCI ? pc + XLEN'(4) : rf[rb];

    assign ext = imm_src == 2'b00 ? XLEN'(iw[7:0])
               : imm_src == 2'b01 ? XLEN'(iw[11:0])
               : imm_src == 2'b10 ? XLEN'({{XLEN{iw[23]}}, iw}) : '0;

    assign asr     = $signed(wd_q) >>> shamt;
    assign rot     = 5'(int'(shamt) % XLEN);
    assign shifted = sh == 2'd0 ? wd_q << shamt
                   : sh == 2'd1 ? wd_q >> shamt
                   : sh == 2'd2 ? asr
                   : (wd_q >> rot) | (wd_q << (XLEN - int'(rot)));

    assign srcb   = op_class == DP_REG ? shifted : ext;
    assign sub_op = alu_ctrl == ALU_SUB;
    assign arith  = alu_ctrl == ALU_ADD || sub_op;
    assign srcb_n = sub_op ? ~srcb : srcb;
    assign sum    = {1'b0, a_q} + {1'b0, srcb_n} + (XLEN + 1)'(sub_op);
    assign ovf    = (a_q[XLEN-1] == srcb_n[XLEN-1]) && (sum[XLEN-1] != a_q[XLEN-1]);

    assign res = arith                ? sum[XLEN-1:0]
               : alu_ctrl == ALU_AND  ? a_q & srcb
               : alu_ctrl == ALU_ORR  ? a_q | srcb
               : alu_ctrl == ALU_EOR  ? a_q ^ srcb
               : alu_ctrl == ALU_MOV  ? srcb
               : alu_ctrl == ALU_BIC  ? a_q & ~srcb : ~srcb;

    // logical ops leave C and V as they were
    assign nzcv = {res[XLEN-1], res == '0,
                   arith ? sum[XLEN] : alu_flags[1],
                   arith ? ovf : alu_flags[0]};

    assign adr    = iw[U_BIT] ? a_q + ext : a_q - ext;
    assign wb_val = c.rf_data ? data_q : alu_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc        <= RESET_PC;
            alu_flags <= '0;
            instr     <= '0;
        end else begin
            if (c.ir_we) begin
                instr <= mem_rdata;
                pc    <= pc + XLEN'(4);
            end
            if (c.ex_we && flag_we) alu_flags <= nzcv;
            if ((c.rf_alu || c.rf_data) && rd == PCI) pc <= wb_val;
            if (c.br_we) pc <= a_q + (ext << 2);
        end
    end

    always_ff @(posedge clk) begin
        if (c.rd_we) begin
            a_q  <= a_rd;
            wd_q <= b_rd;
        end
        if (c.ex_we) alu_q <= res;
        if (c.adr_we) alu_q <= adr;
        if (c.data_we) data_q <= mem_rdata;
    end

    always_ff @(posedge clk)
        if ((c.rf_alu || c.rf_data) && rd < PCI) rf[rd] <= wb_val;

    assign mem_req   = c.mem_req;
    assign mem_we    = c.mem_we;
    assign mem_addr  = c.addr_alu ? alu_q : pc;
    assign mem_wdata = wd_q;
    assign retire    = c.retire;
    assign state     = st;

endmodule

// File: tb/tb_mc_datapath.sv
// tb_mc_datapath: directed program run through mc_datapath with a bench-side
// memory responder and hand-computed expectations.
module tb_mc_datapath;
    import mc_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    op_t         op_class;
    logic [2:0]  alu_ctrl;
    logic [1:0]  imm_src;
    logic        flag_we, cond_ex;
    logic [31:0] instr;
    logic [3:0]  alu_flags;
    logic        mem_req, mem_we, mem_ready, retire;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  state;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc, ret, we_cyc;
    logic [31:0] fa, st_addr, st_data;

    mc_datapath #(.XLEN(32), .NREGS(16), .RESET_PC(32'h100)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .op_class (op_class),
        .alu_ctrl (alu_ctrl),
        .imm_src  (imm_src),
        .flag_we  (flag_we),
        .cond_ex  (cond_ex),
        .instr    (instr),
        .alu_flags(alu_flags),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .retire   (retire),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic u, input logic [3:0] rn, input logic [3:0] rd,
                                        input logic [11:0] lo);
        return {4'hE, 4'h0, u, 3'b000, rn, rd, lo};
    endfunction

    // Acts as decoder and memory for one instruction: fw/dw are wait cycles
    // before ready in the fetch and data phases; stops at retire or after mx cycles.
    task automatic run(input logic [31:0] w, input op_t oc, input logic [2:0] ac,
                       input logic [1:0] is, input logic fwe, input logic ce,
                       input int fw, input int dw, input int mx, input logic [31:0] dv);
        int   wcnt;
        logic fetched, hs, rq, done;
        wcnt = 0; fetched = 1'b0;
        cyc = 0; ret = 0; we_cyc = 0; fa = '1; st_addr = '1; st_data = '1;
        for (int i = 1; i <= mx; i++) begin
            @(negedge clk);
            if (i == 1) begin
                op_class = oc; alu_ctrl = ac; imm_src = is; flag_we = fwe; cond_ex = ce;
            end
            mem_ready = mem_req && wcnt >= (fetched ? dw : fw);
            mem_rdata = fetched ? dv : w;
            #1;
            cyc  = i;
            rq   = mem_req;
            hs   = mem_req && mem_ready;
            done = retire;
            if (retire) ret++;
            if (mem_req && mem_we) begin
                we_cyc++;
                st_addr = mem_addr;
                st_data = mem_wdata;
            end
            if (hs && !fetched) fa = mem_addr;
            @(posedge clk);
            if (hs) begin
                wcnt = 0;
                fetched = 1'b1;
            end else if (rq) wcnt++;
            if (done) break;
        end
    endtask

    initial begin
        reset_n = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
        op_class = DP_IMM; alu_ctrl = ALU_ADD; imm_src = 2'b00; flag_we = 1'b0; cond_ex = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("rst_state", 32'(state), 32'(FETCH));
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_retire", 32'(retire), 32'd0);
        check("rst_flags", 32'(alu_flags), 32'd0);
        check("rst_instr", instr, 32'd0);
        reset_n = 1'b1; #1;
        check("rel_req", 32'(mem_req), 32'd1);
        check("rel_addr", mem_addr, 32'h100);
        check("rel_retire", 32'(retire), 32'd0);

        run(enc(1, 0, 2, 12'd7), DP_IMM, ALU_MOV, 2'b00, 0, 1, 0, 0, 40, 0);
        check("mov_r2_fa", fa, 32'h100);
        run(enc(1, 2, 1, 12'd5), DP_IMM, ALU_ADD, 2'b00, 1, 1, 0, 0, 40, 0);
        check("add_cyc", cyc, 4);
        check("add_ret", ret, 1);
        check("add_fa", fa, 32'h104);
        check("add_instr", instr, enc(1, 2, 1, 12'd5));
        check("add_flags", 32'(alu_flags), 32'd0);
        run(enc(1, 0, 0, 12'h40), DP_IMM, ALU_MOV, 2'b00, 0, 1, 0, 0, 40, 0);
        run(enc(1, 0, 1, 12'd0), STR, ALU_ADD, 2'b01, 0, 1, 0, 0, 40, 0);
        check("add_r1_val", st_data, 32'd12);
        check("str_r1_addr", st_addr, 32'h40);
        check("str_r1_fa", fa, 32'h10C);

        run(enc(1, 0, 4, 12'h55), DP_IMM, ALU_MOV, 2'b00, 0, 1, 0, 0, 40, 0);
        run(enc(1, 0, 4, 12'd4), STR, ALU_ADD, 2'b01, 0, 1, 0, 0, 40, 0);
        check("str_cyc", cyc, 4);
        check("str_we_cyc", we_cyc, 1);
        check("str_addr", st_addr, 32'h44);
        check("str_wdata", st_data, 32'h55);
        check("str_ret", ret, 1);

        run(enc(1, 0, 3, 12'd8), LDR, ALU_ADD, 2'b01, 0, 1, 0, 2, 40, 32'hDEADBEEF);
        check("ldr_cyc", cyc, 7);
        check("ldr_ret", ret, 1);
        check("ldr_no_we", we_cyc, 0);
        run(enc(1, 0, 3, 12'd0), STR, ALU_ADD, 2'b01, 0, 1, 1, 0, 40, 0);
        check("ldr_r3_val", st_data, 32'hDEADBEEF);
        check("fwait_cyc", cyc, 5);
        check("fwait_fa", fa, 32'h11C);

        run(enc(1, 2, 6, {5'd2, 2'd0, 1'b0, 4'd1}), DP_REG, ALU_ADD, 2'b00, 0, 1, 0, 0, 40, 0);
        run(enc(0, 0, 6, 12'd4), STR, ALU_ADD, 2'b01, 0, 1, 0, 0, 40, 0);
        check("lsl_add_val", st_data, 32'd55);
        check("str_down_addr", st_addr, 32'h3C);

        run(enc(1, 2, 5, 12'd7), DP_IMM, ALU_SUB, 2'b00, 1, 1, 0, 0, 40, 0);
        check("subs_flags", 32'(alu_flags), 32'b0110);
        run(enc(1, 0, 2, 12'd99), DP_IMM, ALU_MOV, 2'b00, 0, 0, 0, 0, 40, 0);
        check("cfail_cyc", cyc, 2);
        check("cfail_ret", ret, 1);
        run(enc(1, 0, 2, 12'd0), STR, ALU_ADD, 2'b01, 0, 1, 0, 0, 40, 0);
        check("cfail_r2_kept", st_data, 32'd7);
        check("cfail_pc", fa, 32'h130);

        run(enc(1, 0, 15, 12'h200), DP_IMM, ALU_MOV, 2'b01, 0, 1, 0, 0, 40, 0);
        run({8'hEA, 24'd2}, BR, ALU_ADD, 2'b10, 0, 1, 0, 0, 40, 0);
        check("br_fa", fa, 32'h200);
        check("br_cyc", cyc, 3);
        check("br_ret", ret, 1);
        run(enc(1, 0, 5, 12'd0), STR, ALU_ADD, 2'b01, 0, 1, 0, 0, 40, 0);
        check("br_target", fa, 32'h210);
        check("subs_r5_val", st_data, 32'd0);
        check("flags_kept", 32'(alu_flags), 32'b0110);

        run(enc(1, 0, 3, 12'd8), LDR, ALU_ADD, 2'b01, 0, 1, 0, 10, 4, 32'h12345678);
        @(negedge clk);
        mem_ready = 1'b0; #1;
        check("abort_state", 32'(state), 32'(MEMRD));
        check("abort_addr", mem_addr, 32'h48);
        reset_n = 1'b0; #1;
        check("abort_req_low", 32'(mem_req), 32'd0);
        @(negedge clk); #1;
        check("abort_fetch", 32'(state), 32'(FETCH));
        check("abort_req_held", 32'(mem_req), 32'd0);
        check("abort_retire", 32'(retire), 32'd0);
        reset_n = 1'b1; #1;
        check("abort_req_rel", 32'(mem_req), 32'd1);
        check("abort_pc", mem_addr, 32'h100);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
